// File: rtl/bip_pkg.sv
// Shared BIP definitions: default widths, the HALT opcode and the program
// loader state encoding.
package bip_pkg;

  localparam int LEN_DATA   = 16;
  localparam int LEN_ADDR   = 11;
  localparam int LEN_OPCODE = 5;
  localparam int LEN_BYTE   = 8;

  // Also decoded by the instruction decoder; keep the two in step.
  localparam logic [4:0] OPC_HALT = 5'b00000;

  typedef enum logic [2:0] {
    ST_WAIT_LO = 3'd0,
    ST_WAIT_HI = 3'd1,
    ST_WRITE   = 3'd2,
    ST_START   = 3'd3,
    ST_DONE    = 3'd4
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Two-byte latch that builds an instruction word, low byte first.
// o_complete is the word that the current byte finishes when it is the high byte.
module word_assembler #(
  parameter int len_byte = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_load_lo,
  input  logic                  i_load_hi,
  input  logic [len_byte-1:0]   i_byte,
  output logic [2*len_byte-1:0] o_word,
  output logic [2*len_byte-1:0] o_complete
);

  logic [len_byte-1:0] r_lo;
  logic [len_byte-1:0] r_hi;

  // Byte registers; a clear discards any partially received word.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_lo <= '0;
      r_hi <= '0;
    end else begin
      if (i_load_lo) begin
        r_lo <= i_byte;
      end
      if (i_load_hi) begin
        r_hi <= i_byte;
      end
    end
  end

  assign o_word     = {r_hi, r_lo};
  assign o_complete = {i_byte, r_lo};

endmodule

// File: rtl/bip_program_loader.sv
// Loads a BIP program from a received byte stream into program memory,
// then pulses start to release the PC.
module bip_program_loader
  import bip_pkg::*;
#(
  parameter int len_data   = LEN_DATA,
  parameter int len_addr   = LEN_ADDR,
  parameter int len_opcode = LEN_OPCODE,
  parameter int len_byte   = LEN_BYTE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [len_byte-1:0] rx_data,
  input  logic                rx_done,
  input  logic                reload,
  output logic [len_addr-1:0] prog_addr,
  output logic [len_data-1:0] prog_data,
  output logic                prog_wr_en,
  output logic                start,
  output logic                loading,
  output logic                loaded
);

  loader_state_t         r_state;
  loader_state_t         w_next;
  logic [len_addr-1:0]   r_count;
  logic [len_addr-1:0]   r_prog_addr;
  logic [len_data-1:0]   r_prog_data;
  logic [len_data-1:0]   w_word;
  logic [len_data-1:0]   w_complete;
  logic [len_opcode-1:0] w_opcode;
  logic                  w_terminal;
  logic                  w_load_lo;
  logic                  w_load_hi;

  assign w_opcode   = w_word[len_data-1:len_addr];
  assign w_terminal = (w_opcode == len_opcode'(OPC_HALT)) ||
                      (r_count == {len_addr{1'b1}});

  // A byte arriving during a non-terminal write already belongs to the next word.
  assign w_load_lo = rx_done && !reload &&
                     ((r_state == ST_WAIT_LO) || ((r_state == ST_WRITE) && !w_terminal));
  assign w_load_hi = rx_done && !reload && (r_state == ST_WAIT_HI);

  word_assembler #(.len_byte(len_byte)) u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (reload),
    .i_load_lo  (w_load_lo),
    .i_load_hi  (w_load_hi),
    .i_byte     (rx_data),
    .o_word     (w_word),
    .o_complete (w_complete)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_WAIT_LO;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; reload wins over everything else.
  always_comb begin
    w_next = r_state;
    if (reload) begin
      w_next = ST_WAIT_LO;
    end else begin
      case (r_state)
        ST_WAIT_LO: w_next = rx_done ? ST_WAIT_HI : ST_WAIT_LO;
        ST_WAIT_HI: w_next = rx_done ? ST_WRITE : ST_WAIT_HI;
        ST_WRITE: begin
          if (w_terminal) begin
            w_next = ST_START;
          end else if (rx_done) begin
            w_next = ST_WAIT_HI;
          end else begin
            w_next = ST_WAIT_LO;
          end
        end
        ST_START:   w_next = ST_DONE;
        ST_DONE:    w_next = ST_DONE;
        default:    w_next = ST_WAIT_LO;
      endcase
    end
  end

  // Word counter and write-port registers, which hold outside the write cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_prog_addr <= '0;
      r_prog_data <= '0;
    end else if (reload) begin
      r_count <= '0;
    end else begin
      if (w_load_hi) begin
        r_prog_addr <= r_count;
        r_prog_data <= w_complete;
      end
      if ((r_state == ST_WRITE) && !w_terminal) begin
        r_count <= r_count + len_addr'(1);
      end
    end
  end

  // Strobes decoded from the registered state.
  always_comb begin
    prog_wr_en = 1'b0;
    start      = 1'b0;
    loading    = 1'b0;
    loaded     = 1'b0;
    case (r_state)
      ST_WAIT_LO: loading = 1'b1;
      ST_WAIT_HI: loading = 1'b1;
      ST_WRITE: begin
        loading    = 1'b1;
        prog_wr_en = 1'b1;
      end
      ST_START:   start  = 1'b1;
      ST_DONE:    loaded = 1'b1;
      default:    loading = 1'b0;
    endcase
  end

  assign prog_addr = r_prog_addr;
  assign prog_data = r_prog_data;

endmodule

// File: tb/tb_bip_program_loader.sv
// Self-checking bench for bip_program_loader: table-driven words plus a write
// scoreboard fed at stimulus time and drained by a write-port monitor.
module tb_bip_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        reload = 1'b0;
  logic [10:0] prog_addr;
  logic [15:0] prog_data;
  logic        prog_wr_en;
  logic        start;
  logic        loading;
  logic        loaded;

  typedef struct {
    logic [10:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [10:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[2];
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_writes = 0;
  logic mon_en = 1'b0;

  bip_program_loader dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .reload     (reload),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_wr_en (prog_wr_en),
    .start      (start),
    .loading    (loading),
    .loaded     (loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Write-port monitor: every write must match the head of the scoreboard.
  always begin
    @(posedge clk);
    #2;
    if (mon_en && prog_wr_en === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {21'd0, prog_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", {21'd0, prog_addr}, {21'd0, e.addr});
        chk("write_data", {16'd0, prog_data}, {16'd0, e.data});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] lo, input logic [7:0] hi,
                           input logic [10:0] addr);
    wr_t e;
    e.addr = addr;
    e.data = {hi, lo};
    exp_q.push_back(e);
    send_byte(lo);
    send_byte(hi);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  // Called right after the terminal high byte: start next cycle, then loaded.
  task automatic check_finish(input string name);
    @(posedge clk);
    #2;
    chk({name, "_start"}, {31'd0, start}, 32'd1);
    chk({name, "_loading_off"}, {31'd0, loading}, 32'd0);
    chk({name, "_not_loaded_yet"}, {31'd0, loaded}, 32'd0);
    @(posedge clk);
    #2;
    chk({name, "_start_one_cycle"}, {31'd0, start}, 32'd0);
    chk({name, "_loaded"}, {31'd0, loaded}, 32'd1);
    chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_addr"}, {21'd0, prog_addr}, 32'd0);
    chk({name, "_data"}, {16'd0, prog_data}, 32'd0);
    chk({name, "_wr_en"}, {31'd0, prog_wr_en}, 32'd0);
    chk({name, "_start"}, {31'd0, start}, 32'd0);
    chk({name, "_loaded"}, {31'd0, loaded}, 32'd0);
    chk({name, "_loading"}, {31'd0, loading}, 32'd1);
  endtask

  initial begin
    int w0;
    vecs[0] = '{lo: 8'h05, hi: 8'h08, exp_addr: 11'd0, exp_data: 16'h0805};
    vecs[1] = '{lo: 8'h00, hi: 8'h00, exp_addr: 11'd1, exp_data: 16'h0000};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_values("reset");
    mon_en = 1'b1;

    // Test 1: table-driven two-word program ending in HALT.
    for (int i = 0; i < 2; i++) begin
      send_word(vecs[i].lo, vecs[i].hi, vecs[i].exp_addr);
    end
    check_finish("t1");

    // Test 2: next low byte arrives during the write cycle of word 0.
    pulse_reload();
    chk("t2_reload_loading", {31'd0, loading}, 32'd1);
    chk("t2_reload_loaded", {31'd0, loaded}, 32'd0);
    exp_q.push_back('{addr: 11'd0, data: 16'h0811});
    exp_q.push_back('{addr: 11'd1, data: 16'h0922});
    send_byte(8'h11);
    @(negedge clk);
    rx_data = 8'h08;
    rx_done = 1'b1;
    @(negedge clk);
    chk("t2_write_cycle", {31'd0, prog_wr_en}, 32'd1);
    rx_data = 8'h22;
    @(negedge clk);
    rx_done = 1'b0;
    send_byte(8'h09);
    send_word(8'h00, 8'h00, 11'd2);
    check_finish("t2");

    // Test 3: reload after three bytes drops the partial word.
    pulse_reload();
    send_word(8'h01, 8'h08, 11'd0);
    send_byte(8'h55);
    w0 = n_writes;
    pulse_reload();
    chk("t3_no_partial_write", n_writes, w0);
    send_word(8'h34, 8'h12, 11'd0);
    send_word(8'h00, 8'h00, 11'd1);
    check_finish("t3");

    // Test 4: full memory of non-HALT words ends at the last address.
    pulse_reload();
    for (int i = 0; i < 2048; i++) begin
      logic [10:0] a;
      a = 11'(i);
      send_word(a[7:0], {5'b00001, a[10:8]}, a);
    end
    chk("t4_last_addr", {21'd0, prog_addr}, 32'h7FF);
    check_finish("t4");
    w0 = n_writes;
    send_byte(8'h01);
    send_byte(8'h08);
    repeat (3) @(negedge clk);
    chk("t4_no_write_after_full", n_writes, w0);

    // Test 5: reset while waiting for the high byte of word 3.
    pulse_reload();
    for (int i = 0; i < 3; i++) begin
      send_word(8'(8'h40 + i), 8'h0C, 11'(i));
    end
    send_byte(8'h77);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("t5_reset");
    send_word(8'h34, 8'h12, 11'd0);
    send_word(8'h00, 8'h00, 11'd1);
    check_finish("t5");

    // Test 6: bytes in DONE are ignored; reload restarts at address 0.
    w0 = n_writes;
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (3) @(negedge clk);
    chk("t6_no_write_in_done", n_writes, w0);
    chk("t6_still_loaded", {31'd0, loaded}, 32'd1);
    pulse_reload();
    send_word(8'h78, 8'h56, 11'd0);
    send_word(8'h00, 8'h00, 11'd1);
    check_finish("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
